// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce bank.
//   deb_state_e    : per-channel debounce FSM state; bit[1] is the accepted level
//   stab_cnt_width : width of a stability counter that must reach STABLE_TICKS
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } deb_state_e;

   function automatic int unsigned stab_cnt_width(input int unsigned ticks);
      return (ticks < 1) ? 1 : $clog2(ticks + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 4-state FSM plus saturating stability counter.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   tick         : shared timer pulse from the prescaler
//   din          : raw (or synchronized) channel input
//   level        : accepted level, taken straight from a state flop
//   rise_c       : combinational pulse, WAIT_HIGH->HIGH taken this cycle
//   fall_c       : combinational pulse, WAIT_LOW->LOW taken this cycle
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = 20
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic din,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   localparam int unsigned CW = stab_cnt_width(STABLE_TICKS);

   deb_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_c;

   assign done_c = (cnt_q == CW'(STABLE_TICKS));

   // HIGH and WAIT_LOW share bit[1], so the level is a plain flop output
   assign level = state_q[1];

   // Next-state, counter and event pulses
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_c  = 1'b0;
      fall_c  = 1'b0;
      case (state_q)
         ST_LOW: begin
            cnt_d = '0;
            if (din) state_d = ST_WAIT_HIGH;
         end
         ST_WAIT_HIGH: begin
            if (tick && !done_c) cnt_d = cnt_q + CW'(1);
            if (!din) begin
               state_d = ST_LOW;
            end else if (done_c) begin
               state_d = ST_HIGH;
               rise_c  = 1'b1;
            end
         end
         ST_HIGH: begin
            cnt_d = '0;
            if (!din) state_d = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (tick && !done_c) cnt_d = cnt_q + CW'(1);
            if (din) begin
               state_d = ST_HIGH;
            end else if (done_c) begin
               state_d = ST_LOW;
               fall_c  = 1'b1;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/debounce_bank_ctrl.sv
// Bank of N_CH debouncers sharing one prescaler, with a round-robin event
// queue (one pending slot per channel) and sticky overrun flags.
// Optional macro: DEB_SYNC_EN adds a two-flop input synchronizer.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   noisy[N_CH]           : raw inputs
//   debounced[N_CH]       : accepted levels
//   evt_valid/evt_ready   : edge-event handshake
//   evt_ch, evt_rise      : channel and direction of presented event
//   overrun[N_CH]         : sticky lost-event flags, ovr_clr clears per bit
module debounce_bank_ctrl
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned STABLE_TICKS = 20
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_CH-1:0]         noisy,
   output logic [N_CH-1:0]         debounced,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [$clog2(N_CH)-1:0] evt_ch,
   output logic                    evt_rise,
   output logic [N_CH-1:0]         overrun,
   input  logic [N_CH-1:0]         ovr_clr
);

   localparam int unsigned CH_W = $clog2(N_CH);
   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] ps_q, ps_d;
   logic            tick_c;
   logic [N_CH-1:0] din_c, rise_c, fall_c;
   logic [N_CH-1:0] pend_q, pend_d, dir_q, dir_d, ovr_q, ovr_d, ovr_set_c;
   logic            evt_valid_q, evt_valid_d, evt_rise_q, evt_rise_d;
   logic [CH_W-1:0] evt_ch_q, evt_ch_d, rr_q, rr_d, gnt_c, idx_c;
   logic            found_c, load_en_c;

   // Input conditioning
`ifdef DEB_SYNC_EN
   logic [N_CH-1:0] sync1_q, sync2_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= noisy;
         sync2_q <= sync1_q;
      end
   end
   assign din_c = sync2_q;
`else
   assign din_c = noisy;
`endif

   // Shared tick prescaler
   assign tick_c = (ps_q == PS_W'(PRESCALE - 1));
   assign ps_d   = tick_c ? '0 : ps_q + PS_W'(1);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(.STABLE_TICKS(STABLE_TICKS)) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .tick    (tick_c),
         .din     (din_c[g]),
         .level   (debounced[g]),
         .rise_c  (rise_c[g]),
         .fall_c  (fall_c[g])
      );
   end

   // Round-robin grant, event register load, pend/overrun bookkeeping
   always_comb begin
      found_c     = 1'b0;
      gnt_c       = '0;
      idx_c       = '0;
      load_en_c   = !evt_valid_q || evt_ready;
      evt_valid_d = evt_valid_q;
      evt_ch_d    = evt_ch_q;
      evt_rise_d  = evt_rise_q;
      rr_d        = rr_q;
      pend_d      = pend_q;
      dir_d       = dir_q;
      ovr_set_c   = '0;

      // search starts just after the last granted channel
      for (int k = 1; k <= int'(N_CH); k++) begin
         idx_c = CH_W'((int'(rr_q) + k) % int'(N_CH));
         if (!found_c && pend_q[idx_c]) begin
            found_c = 1'b1;
            gnt_c   = idx_c;
         end
      end

      if (load_en_c) begin
         if (found_c) begin
            evt_valid_d   = 1'b1;
            evt_ch_d      = gnt_c;
            evt_rise_d    = dir_q[gnt_c];
            pend_d[gnt_c] = 1'b0;
            rr_d          = gnt_c;
         end else begin
            evt_valid_d = 1'b0;
         end
      end

      // a new event on the channel being loaded just re-arms pend
      for (int i = 0; i < int'(N_CH); i++) begin
         if (rise_c[i] || fall_c[i]) begin
            if (pend_q[i] && !(load_en_c && found_c && gnt_c == CH_W'(i)))
               ovr_set_c[i] = 1'b1;
            pend_d[i] = 1'b1;
            dir_d[i]  = rise_c[i];
         end
      end

      ovr_d = (ovr_q & ~ovr_clr) | ovr_set_c;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps_q        <= '0;
         pend_q      <= '0;
         dir_q       <= '0;
         ovr_q       <= '0;
         evt_valid_q <= 1'b0;
         evt_ch_q    <= '0;
         evt_rise_q  <= 1'b0;
         rr_q        <= CH_W'(N_CH - 1);
      end else begin
         ps_q        <= ps_d;
         pend_q      <= pend_d;
         dir_q       <= dir_d;
         ovr_q       <= ovr_d;
         evt_valid_q <= evt_valid_d;
         evt_ch_q    <= evt_ch_d;
         evt_rise_q  <= evt_rise_d;
         rr_q        <= rr_d;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_ch    = evt_ch_q;
   assign evt_rise  = evt_rise_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_debounce_bank_ctrl.sv
// Bench for debounce_bank_ctrl with N_CH=4, PRESCALE=4, STABLE_TICKS=3.
module tb_debounce_bank_ctrl;

   localparam int unsigned N_CH = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N_CH-1:0] noisy, debounced, overrun, ovr_clr;
   logic            evt_valid, evt_ready, evt_rise;
   logic [1:0]      evt_ch;

   typedef struct packed {
      logic [1:0] ch;
      logic       rise;
   } ev_t;

   ev_t sb[$];
   int  hs_cyc[$];
   int  cyc = 0;
   int  total = 0;
   int  bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   debounce_bank_ctrl #(.N_CH(4), .PRESCALE(4), .STABLE_TICKS(3)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .noisy     (noisy),
      .debounced (debounced),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_ch    (evt_ch),
      .evt_rise  (evt_rise),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr)
   );

   // Monitor: every handshake pops one expected event
   always @(negedge clk) begin
      ev_t e;
      if (reset_n && evt_valid && evt_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL evt_unexpected got ch=%0d rise=%0d, wanted no event", evt_ch, evt_rise);
         end else begin
            e = sb.pop_front();
            if (e.ch !== evt_ch || e.rise !== evt_rise) begin
               bad++;
               $display("FAIL evt_payload got ch=%0d rise=%0d, wanted ch=%0d rise=%0d",
                        evt_ch, evt_rise, e.ch, e.rise);
            end
         end
         hs_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h wanted=%0h", name, act, exp);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input logic [1:0] ch, input logic rise);
      ev_t e;
      e.ch   = ch;
      e.rise = rise;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         cyc_wait(1);
         n++;
      end
      cyc_wait(2);
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_consec(input string name);
      int n;
      n = hs_cyc.size();
      if (n >= 3) chk(name, 32'(hs_cyc[n-1] - hs_cyc[n-3]), 32'd2);
      else        chk(name, 32'(n), 32'd3);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      noisy   = '0;
      ovr_clr = '0;
      cyc_wait(2);
      reset_n = 1'b1;
      cyc_wait(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout wanted=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      noisy     = '0;
      evt_ready = 1'b1;
      ovr_clr   = '0;
      cyc_wait(3);
      chk("rst_debounced", 32'(debounced), 32'd0);
      chk("rst_evt_valid", 32'(evt_valid), 32'd0);
      chk("rst_evt_ch",    32'(evt_ch),    32'd0);
      chk("rst_evt_rise",  32'(evt_rise),  32'd0);
      chk("rst_overrun",   32'(overrun),   32'd0);
      reset_n = 1'b1;
      cyc_wait(1);

      // Single channel rise then fall
      push_ev(2'd0, 1'b1);
      noisy[0] = 1'b1;
      cyc_wait(5);
      chk("t1_early_low", 32'(debounced[0]), 32'd0);
      cyc_wait(15);
      chk("t1_high", 32'(debounced[0]), 32'd1);
      drain("t1_rise_drain");
      chk("t1_valid_drop", 32'(evt_valid), 32'd0);
      push_ev(2'd0, 1'b0);
      noisy[0] = 1'b0;
      cyc_wait(20);
      chk("t1_low", 32'(debounced[0]), 32'd0);
      drain("t1_fall_drain");

      // Short glitch is rejected
      noisy[1] = 1'b1;
      cyc_wait(5);
      noisy[1] = 1'b0;
      cyc_wait(25);
      chk("t2_glitch_level", 32'(debounced[1]), 32'd0);
      chk("t2_glitch_evt",   32'(evt_valid),    32'd0);

      // Three channels accepted on the same edge
      do_reset();
      push_ev(2'd0, 1'b1);
      push_ev(2'd2, 1'b1);
      push_ev(2'd3, 1'b1);
      noisy = 4'b1101;
      cyc_wait(20);
      chk("t3_levels", 32'(debounced), 32'hd);
      drain("t3_rise_drain");
      chk_consec("t3_rise_consec");
      push_ev(2'd0, 1'b0);
      push_ev(2'd2, 1'b0);
      push_ev(2'd3, 1'b0);
      noisy = 4'b0000;
      cyc_wait(20);
      drain("t3_fall_drain");
      chk_consec("t3_fall_consec");

      // Overrun on ch 2 while event register is held
      evt_ready = 1'b0;
      push_ev(2'd3, 1'b1);
      noisy[3] = 1'b1;
      cyc_wait(20);
      chk("t4_hold_valid", 32'(evt_valid), 32'd1);
      chk("t4_hold_ch",    32'(evt_ch),    32'd3);
      push_ev(2'd2, 1'b0);
      noisy[2] = 1'b1;
      cyc_wait(20);
      noisy[2] = 1'b0;
      cyc_wait(20);
      chk("t4_overrun_set", 32'(overrun), 32'h4);
      chk("t4_stable_ch",   32'(evt_ch),   32'd3);
      chk("t4_stable_rise", 32'(evt_rise), 32'd1);
      evt_ready = 1'b1;
      drain("t4_drain");
      chk("t4_overrun_sticky", 32'(overrun), 32'h4);
      ovr_clr[2] = 1'b1;
      cyc_wait(1);
      ovr_clr = '0;
      chk("t4_overrun_clr", 32'(overrun), 32'h0);

      // Reset while an event is presented and another is pending
      push_ev(2'd3, 1'b0);
      noisy[3] = 1'b0;
      cyc_wait(20);
      drain("t5_pre_drain");
      evt_ready = 1'b0;
      noisy[0] = 1'b1;
      cyc_wait(20);
      noisy[1] = 1'b1;
      cyc_wait(20);
      chk("t5_valid_before", 32'(evt_valid), 32'd1);
      chk("t5_levels_before", 32'(debounced), 32'h3);
      reset_n = 1'b0;
      noisy   = '0;
      cyc_wait(1);
      chk("t5_rst_debounced", 32'(debounced), 32'd0);
      chk("t5_rst_valid",     32'(evt_valid), 32'd0);
      chk("t5_rst_rise",      32'(evt_rise),  32'd0);
      chk("t5_rst_overrun",   32'(overrun),   32'd0);
      reset_n   = 1'b1;
      evt_ready = 1'b1;
      cyc_wait(30);
      chk("t5_no_evt_after", 32'(evt_valid), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/debounce_bank_ctrl.md
DEBOUNCE_BANK_CTRL -- requirements
Module: debounce_bank_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of debounce channels (2..16).
REQ-002 SHALL have parameter PRESCALE, default 50000, clk cycles per shared timer tick (>=2).
REQ-003 SHALL have parameter STABLE_TICKS, default 20, ticks an input must stay stable before acceptance (>=1).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port noisy, input, N_CH, raw per-channel inputs.
REQ-007 SHALL have port debounced, output, N_CH, accepted per-channel levels.
REQ-008 SHALL have port evt_valid, output, 1, edge event available.
REQ-009 SHALL have port evt_ready, input, 1, consumer accepts event.
REQ-010 SHALL have port evt_ch, output, $clog2(N_CH), channel of presented event.
REQ-011 SHALL have port evt_rise, output, 1, 1 = rising edge, 0 = falling edge.
REQ-012 SHALL have port overrun, output, N_CH, sticky lost-event flags.
REQ-013 SHALL have port ovr_clr, input, N_CH, per-bit synchronous clear of overrun.

Function
REQ-014 SHALL run one shared prescaler 0..PRESCALE-1, tick a one-cycle pulse when count = PRESCALE-1, then wrap to 0.
REQ-015 SHALL run per channel a 4-state FSM: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-016 SHALL transition LOW->WAIT_HIGH on input 1; WAIT_HIGH->LOW on input 0; WAIT_HIGH->HIGH on input 1 with stability count done.
REQ-017 SHALL transition HIGH->WAIT_LOW on input 0; WAIT_LOW->HIGH on input 1; WAIT_LOW->LOW on input 0 with count done.
REQ-018 SHALL clear the channel stability counter whenever the FSM is in LOW or HIGH, increment it on tick in WAIT states, and flag done when count = STABLE_TICKS (saturate).
REQ-019 SHALL drive debounced[i] = 1 in HIGH or WAIT_LOW, else 0 (registered state decode, no combinational path from noisy).
REQ-020 SHALL set pend[i] and record direction on WAIT_HIGH->HIGH (rise) or WAIT_LOW->LOW (fall), in the same edge.
REQ-021 SHALL, if pend[i] is already set when a new event occurs, overwrite direction and set overrun[i].
REQ-022 SHALL load the event register when it is empty or being handshaken (evt_valid & evt_ready), choosing among pend bits round-robin starting after the last granted channel, and clear that pend bit.
REQ-023 SHALL give a same-cycle new event on the channel being loaded priority: pend stays set, no overrun.
REQ-024 SHALL hold evt_valid, evt_ch and evt_rise stable until evt_ready is sampled high.
REQ-025 SHALL present an event at minimum one cycle after pend is set (pend at edge T, evt_valid high after edge T+1).
REQ-026 SHALL have ovr_clr[i] take priority below a same-cycle overrun set (set wins).

Reset
REQ-027 SHALL on reset_n low force prescaler 0, all FSMs LOW, counters 0, pend 0, evt_valid 0, evt_ch 0, evt_rise 0, overrun 0, round-robin pointer to channel N_CH-1 (so channel 0 is first).
REQ-028 SHALL discard any in-flight or pending event when reset asserts mid-operation.

Configuration
REQ-029 SHALL, with DEB_SYNC_EN defined, pass noisy through a two-flop synchronizer (reset 0), adding two cycles of input latency.
REQ-030 SHALL, without DEB_SYNC_EN, feed noisy directly to the FSMs.

Structure
REQ-031 SHALL place the FSM state enum (LOW, WAIT_HIGH, HIGH, WAIT_LOW) and the stability counter width function in package debounce_pkg.
REQ-032 SHALL implement one FSM plus stability counter as sub-module debounce_channel, instantiated N_CH times; prescaler and arbiter stay in the top.

Verification (N_CH=4, PRESCALE=4, STABLE_TICKS=3, DEB_SYNC_EN off)
REQ-033 SHALL cover: hold noisy[0]=1 for 12+ cycles -> debounced[0]=1 after the 3rd tick in WAIT_HIGH; one event ch=0 rise=1.
REQ-034 SHALL cover: noisy[1] glitch high for 5 cycles -> debounced[1] stays 0, no event.
REQ-035 SHALL cover: channels 0,2,3 reach HIGH on the same edge with evt_ready=1 -> events ch 0,2,3 on consecutive cycles.
REQ-036 SHALL cover: evt_ready=0 while ch 2 rises then falls -> overrun[2]=1; after ready, one event ch=2 rise=0; ovr_clr[2] pulse -> overrun[2]=0.
REQ-037 SHALL cover: reset_n pulsed low with evt_valid=1 and pend set -> all outputs 0 next cycle, no event after release.
